// File: rtl/elevator_ctrl_nfloor_pkg.sv
// Shared types and helpers for the N-floor lift controller: state encoding,
// default timing constants, one-hot decode and above/below call masks.
package elevator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MOVE_UP   = 3'd1,
    ST_MOVE_DOWN = 3'd2,
    ST_DOOR_OPEN = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  localparam int DEF_FLOORS            = 4;
  localparam int DEF_DOOR_CYCLES       = 8;
  localparam int DEF_MAX_TRAVEL_CYCLES = 1024;
  localparam int MAX_FLOORS            = 16;

  // Helpers work on the widest supported floor count; callers zero-extend.
  function automatic logic is_onehot(input logic [MAX_FLOORS-1:0] v);
    return (v != '0) && ((v & (v - 16'd1)) == '0);
  endfunction

  function automatic logic [3:0] onehot_to_idx(input logic [MAX_FLOORS-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_FLOORS; i++) if (v[i]) idx = 4'(i);
    return idx;
  endfunction

  function automatic logic any_above(input logic [MAX_FLOORS-1:0] v, input logic [3:0] idx);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) if (v[i] && (i > int'(idx))) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic any_below(input logic [MAX_FLOORS-1:0] v, input logic [3:0] idx);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) if (v[i] && (i < int'(idx))) hit = 1'b1;
    return hit;
  endfunction

endpackage

// File: rtl/elevator_ctrl_nfloor_if.sv
// Controller-facing bundle: call buttons and landing sensors in, motor/door
// commands and status out. All signals are levels sampled on clk; no handshake.
interface elevator_ctrl_nfloor_if import elevator_pkg::*; #(
  parameter int FLOORS = DEF_FLOORS
);
  localparam int FLOOR_W = $clog2(FLOORS);

  logic [FLOORS-1:0]  call_req;
  logic [FLOORS-1:0]  floor_sensor;
  logic               motor_up;
  logic               motor_down;
  logic               door_open;
  logic [FLOOR_W-1:0] cur_floor;
  logic [FLOORS-1:0]  pending;
  logic               fault;
  state_e             state_dbg;

  modport master (
    output call_req, floor_sensor,
    input  motor_up, motor_down, door_open, cur_floor, pending, fault, state_dbg
  );

  modport slave (
    input  call_req, floor_sensor,
    output motor_up, motor_down, door_open, cur_floor, pending, fault, state_dbg
  );
endinterface

// File: rtl/elevator_ctrl_nfloor_door_timer.sv
// Door dwell down-counter: load/restart set it to DOOR_CYCLES-1, expired when
// it has counted down to zero.
module elevator_door_timer #(
  parameter int DOOR_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic restart_i,
  output logic expired_o
);
  localparam int CNT_W = (DOOR_CYCLES > 2) ? $clog2(DOOR_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i || restart_i) cnt_d = CNT_W'(DOOR_CYCLES - 1);
    else if (cnt_q != '0)    cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);
endmodule

// File: rtl/elevator_ctrl_nfloor.sv
// N-floor SCAN lift controller. Optional travel watchdog: ELEV_TRAVEL_WDOG_EN
// (adds MAX_TRAVEL_CYCLES and a latched FAULT state; otherwise fault is 0).
module elevator_ctrl_nfloor import elevator_pkg::*; #(
  parameter int FLOORS      = DEF_FLOORS,
  parameter int DOOR_CYCLES = DEF_DOOR_CYCLES
`ifdef ELEV_TRAVEL_WDOG_EN
  , parameter int MAX_TRAVEL_CYCLES = DEF_MAX_TRAVEL_CYCLES
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  elevator_ctrl_nfloor_if.slave bus
);
  localparam int FLOOR_W = $clog2(FLOORS);
  localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(FLOORS - 1);

  state_e             state_q, state_d;
  logic [FLOORS-1:0]  pending_q, pending_d;
  logic [FLOOR_W-1:0] cur_floor_q, cur_floor_d;
  logic               dir_up_q, dir_up_d;

  logic               sensor_valid;
  logic [FLOOR_W-1:0] sensor_idx;
  logic [FLOORS-1:0]  cur_mask, set_mask, clr_mask;
  logic               calls_above, calls_below;
  logic               enter_door, restart_door, door_expired, wd_trip;

  always_comb begin
    sensor_valid = is_onehot(16'(bus.floor_sensor));
    sensor_idx   = FLOOR_W'(onehot_to_idx(16'(bus.floor_sensor)));
    cur_mask     = FLOORS'(1) << cur_floor_q;
    calls_above  = any_above(16'(pending_q), 4'(cur_floor_q));
    calls_below  = any_below(16'(pending_q), 4'(cur_floor_q));
    restart_door = (state_q == ST_DOOR_OPEN) && ((cur_mask & bus.call_req) != '0);
  end

  // A call at the landing the cabin is reaching (or idling at) counts as an
  // arrival: it opens the door rather than being latched.
  always_comb begin
    state_d    = state_q;
    dir_up_d   = dir_up_q;
    enter_door = 1'b0;
    clr_mask   = '0;
    case (state_q)
      ST_IDLE: begin
        if ((cur_mask & (pending_q | bus.call_req)) != '0) begin
          state_d    = ST_DOOR_OPEN;
          enter_door = 1'b1;
          clr_mask   = cur_mask;
        end else if (calls_above && (dir_up_q || !calls_below)) begin
          state_d  = ST_MOVE_UP;
          dir_up_d = 1'b1;
        end else if (calls_below) begin
          state_d  = ST_MOVE_DOWN;
          dir_up_d = 1'b0;
        end
      end
      ST_MOVE_UP, ST_MOVE_DOWN: begin
        if (sensor_valid && ((bus.floor_sensor & (pending_q | bus.call_req)) != '0)) begin
          state_d    = ST_DOOR_OPEN;
          enter_door = 1'b1;
          clr_mask   = bus.floor_sensor;
        end else if (sensor_valid && (state_q == ST_MOVE_UP) && (sensor_idx == TOP)) begin
          state_d = ST_IDLE;
        end else if (sensor_valid && (state_q == ST_MOVE_DOWN) && (sensor_idx == '0)) begin
          state_d = ST_IDLE;
        end
      end
      ST_DOOR_OPEN: begin
        if (!restart_door && door_expired) state_d = ST_IDLE;
      end
      default: state_d = state_q;
    endcase
    if (wd_trip) begin
      state_d    = ST_FAULT;
      enter_door = 1'b0;
      clr_mask   = '0;
    end
  end

  always_comb begin
    set_mask    = (state_q == ST_DOOR_OPEN) ? (bus.call_req & ~cur_mask) : bus.call_req;
    pending_d   = (pending_q | set_mask) & ~clr_mask;
    cur_floor_d = sensor_valid ? sensor_idx : cur_floor_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      cur_floor_q <= '0;
      dir_up_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      cur_floor_q <= cur_floor_d;
      dir_up_q    <= dir_up_d;
    end
  end

  elevator_door_timer #(.DOOR_CYCLES(DOOR_CYCLES)) u_door_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (enter_door),
    .restart_i (restart_door),
    .expired_o (door_expired)
  );

`ifdef ELEV_TRAVEL_WDOG_EN
  localparam int WD_W = $clog2(MAX_TRAVEL_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            moving;

  // Counts motor-on cycles since the last new landing or state change.
  always_comb begin
    moving = (state_q == ST_MOVE_UP) || (state_q == ST_MOVE_DOWN);
    if (!moving || (state_d != state_q) || (sensor_valid && (sensor_idx != cur_floor_q)))
      wd_d = '0;
    else
      wd_d = wd_q + WD_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end

  assign wd_trip   = moving && (wd_q == WD_W'(MAX_TRAVEL_CYCLES - 1));
  assign bus.fault = (state_q == ST_FAULT);
`else
  assign wd_trip   = 1'b0;
  assign bus.fault = 1'b0;
`endif

  assign bus.motor_up   = (state_q == ST_MOVE_UP);
  assign bus.motor_down = (state_q == ST_MOVE_DOWN);
  assign bus.door_open  = (state_q == ST_DOOR_OPEN);
  assign bus.cur_floor  = cur_floor_q;
  assign bus.pending    = pending_q;
  assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_elevator_ctrl_nfloor.sv
// Bench for elevator_ctrl_nfloor (FLOORS=4, DOOR_CYCLES=8): a simple cabin plant
// drives the landing sensors, a behavioural lift model predicts every output.
module tb_elevator_ctrl_nfloor;
  localparam int FLOORS      = 4;
  localparam int DOOR_CYCLES = 8;
  localparam int SPAN        = 4;
  localparam int POS_MAX     = (FLOORS - 1) * SPAN + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  elevator_ctrl_nfloor_if #(.FLOORS(FLOORS)) bus ();

  elevator_ctrl_nfloor #(.FLOORS(FLOORS), .DOOR_CYCLES(DOOR_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, motor_cnt = 0, door_cnt = 0, first_motor = -1;
  int pos = 0;
  bit prev_door = 1'b0;
  logic [1:0] exp_q[$];

  // Behavioural lift: door_left = door cycles still to show, motion = -1/0/+1.
  logic [3:0] m_pend;
  int m_floor, m_motion, m_door;
  bit m_up;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_floor = 0; m_motion = 0; m_door = 0; m_up = 1'b1;
  endtask

  task automatic model_step(input logic [3:0] call, input logic [3:0] sens);
    logic [3:0] req, nxt_pend;
    int sidx, nxt_floor, nxt_motion, nxt_door;
    bit sv, nxt_up, above, below;
    sv = ($countones(sens) == 1);
    sidx = 0;
    for (int k = 0; k < FLOORS; k++) if (sens[k]) sidx = k;
    above = 1'b0; below = 1'b0;
    for (int k = 0; k < FLOORS; k++) begin
      if (m_pend[k] && k > m_floor) above = 1'b1;
      if (m_pend[k] && k < m_floor) below = 1'b1;
    end
    req = m_pend | call;
    nxt_pend = req; nxt_motion = m_motion; nxt_door = m_door; nxt_up = m_up;
    if (m_door > 0) begin
      nxt_pend[m_floor] = m_pend[m_floor];
      nxt_door = call[m_floor] ? DOOR_CYCLES : m_door - 1;
    end else if (m_motion == 0) begin
      if (req[m_floor]) begin
        nxt_door = DOOR_CYCLES; nxt_pend[m_floor] = 1'b0;
      end else if (above && (m_up || !below)) begin
        nxt_motion = 1; nxt_up = 1'b1;
      end else if (below) begin
        nxt_motion = -1; nxt_up = 1'b0;
      end
    end else begin
      if (sv && req[sidx]) begin
        nxt_motion = 0; nxt_door = DOOR_CYCLES; nxt_pend[sidx] = 1'b0;
      end else if (sv && m_motion > 0 && sidx == FLOORS - 1) nxt_motion = 0;
      else if (sv && m_motion < 0 && sidx == 0) nxt_motion = 0;
    end
    nxt_floor = sv ? sidx : m_floor;
    m_pend = nxt_pend; m_floor = nxt_floor; m_motion = nxt_motion; m_door = nxt_door; m_up = nxt_up;
  endtask

  function automatic logic [3:0] sensor_of(input int p);
    logic [3:0] s;
    s = '0;
    for (int k = 0; k < FLOORS; k++) if (p == k * SPAN || p == k * SPAN + 1) s[k] = 1'b1;
    return s;
  endfunction

  task automatic check_outputs();
    int exp_state;
    cyc++;
    exp_state = (m_door > 0) ? 3 : (m_motion == 1) ? 1 : (m_motion == -1) ? 2 : 0;
    check("motor_up", bus.motor_up, m_motion == 1);
    check("motor_down", bus.motor_down, m_motion == -1);
    check("door_open", bus.door_open, m_door > 0);
    check("cur_floor", bus.cur_floor, m_floor);
    check("pending", bus.pending, m_pend);
    check("fault", bus.fault, 0);
    check("state", int'(bus.state_dbg), exp_state);
    check("drive_exclusive", (int'(bus.motor_up) + int'(bus.motor_down) + int'(bus.door_open)) <= 1, 1);
    if (bus.motor_up || bus.motor_down) begin
      motor_cnt++;
      if (first_motor < 0) first_motor = cyc;
    end
    if (bus.door_open) door_cnt++;
    if (bus.door_open && !prev_door && exp_q.size() > 0) check("door_floor", bus.cur_floor, exp_q.pop_front());
    prev_door = bus.door_open;
  endtask

  // mode: 0 clean sensors, 1 occasional multi-hot noise between landings,
  // 2 force 4'b0110, 3 force 4'b1001.
  task automatic tick(input logic [3:0] call, input int mode);
    logic [3:0] sens;
    bit mu, md;
    sens = sensor_of(pos);
    if (mode == 1 && sens == 4'b0000 && $urandom_range(0, 29) == 0) sens = 4'b0110;
    if (mode == 2) sens = 4'b0110;
    if (mode == 3) sens = 4'b1001;
    mu = bus.motor_up; md = bus.motor_down;
    bus.call_req = call; bus.floor_sensor = sens;
    @(posedge clk);
    model_step(call, sens);
    if (mu && pos < POS_MAX) pos++;
    if (md && pos > 0) pos--;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic clr_stats();
    motor_cnt = 0; door_cnt = 0; first_motor = -1;
  endtask

  task automatic run_until_idle(input int max_cycles, input string tag);
    int n;
    n = 0;
    while (!(m_motion == 0 && m_door == 0 && m_pend == 0) && n < max_cycles) begin
      tick(4'b0000, 0);
      n++;
    end
    check(tag, n < max_cycles, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected done");
    $fatal(1, "global timeout");
  end

  initial begin
    int base, dc, n, tgt;
    logic [3:0] pend_seen, call;
    bus.call_req = '0; bus.floor_sensor = 4'b0001;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_motor_up", bus.motor_up, 0);
    check("rst_motor_down", bus.motor_down, 0);
    check("rst_door", bus.door_open, 0);
    check("rst_floor", bus.cur_floor, 0);
    check("rst_pending", bus.pending, 0);
    rst = 1'b0;

    // Call at the floor the cabin rests on: door cycle only.
    clr_stats(); pend_seen = '0;
    tick(4'b0001, 0); pend_seen |= bus.pending;
    repeat (12) begin tick(4'b0000, 0); pend_seen |= bus.pending; end
    check("A_pend_seen", pend_seen, 0);
    check("A_door_len", door_cnt, 8);
    check("A_motor", motor_cnt, 0);

    // Trip to the top floor.
    clr_stats(); base = cyc; exp_q.push_back(2'd3);
    tick(4'b1000, 0);
    run_until_idle(100, "B_timeout");
    check("B_latency", first_motor - base, 2);
    check("B_floor", bus.cur_floor, 3);
    check("B_pending", bus.pending, 0);
    check("B_door_len", door_cnt, 8);

    // Door restart at floor 2 when the timer shows 2.
    exp_q.push_back(2'd2);
    tick(4'b0100, 0);
    n = 0;
    while (!bus.door_open && n < 60) begin tick(4'b0000, 0); n++; end
    dc = 0; n = 0;
    while (bus.door_open && n < 40) begin
      dc++;
      tick((dc == 6) ? 4'b0100 : 4'b0000, 0);
      n++;
    end
    check("C_restart_door_len", dc, 14);
    run_until_idle(20, "C_timeout");

    tick(4'b0000, 2);
    check("D_multihot_0110", bus.cur_floor, 2);
    tick(4'b0000, 3);
    check("D_multihot_1001", bus.cur_floor, 2);

    // Down to 0, up to 1 (dir up), then calls on both sides.
    exp_q.push_back(2'd0); tick(4'b0001, 0); run_until_idle(100, "E0_timeout");
    exp_q.push_back(2'd1); tick(4'b0010, 0); run_until_idle(100, "E1_timeout");
    exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    tick(4'b1001, 0); run_until_idle(200, "E2_timeout");
    check("E_order_done", exp_q.size(), 0);

    // Call for floor 2 just after the cabin passed it going up.
    exp_q.push_back(2'd3); exp_q.push_back(2'd2);
    tick(4'b1000, 0);
    n = 0;
    while (pos != 2 * SPAN + 2 && n < 60) begin tick(4'b0000, 0); n++; end
    check("F_passed_floor2", pos, 2 * SPAN + 2);
    tick(4'b0100, 0);
    run_until_idle(200, "F_timeout");
    check("F_order_done", exp_q.size(), 0);

    // Random calls with sensor noise between landings.
    repeat (1500) begin
      call = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      tick(call, 1);
    end
    run_until_idle(400, "R_drain_timeout");
    check("R_drain_pending", bus.pending, 0);

    // Asynchronous reset mid-travel.
    tgt = (m_floor == 0) ? 3 : 0;
    tick(4'(1 << tgt), 0);
    n = 0;
    while (!(bus.motor_up || bus.motor_down) && n < 10) begin tick(4'b0000, 0); n++; end
    check("G_moving", bus.motor_up || bus.motor_down, 1);
    #2 rst = 1'b1;
    #1;
    check("G_async_motor_up", bus.motor_up, 0);
    check("G_async_motor_down", bus.motor_down, 0);
    check("G_async_pending", bus.pending, 0);
    check("G_async_floor", bus.cur_floor, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
